// File: rtl/waveform_axil_regs_if.sv
// AXI4-Lite bus bundle for the waveform register file.
// The master modport drives the request side; the slave modport answers it.
interface waveform_axil_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                        awprot;
  logic                              awvalid;
  logic                              awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb;
  logic                              wvalid;
  logic                              wready;
  logic [1:0]                        bresp;
  logic                              bvalid;
  logic                              bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                        arprot;
  logic                              arvalid;
  logic                              arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     rdata;
  logic [1:0]                        rresp;
  logic                              rvalid;
  logic                              rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/waveform_axil_regs.sv
// AXI4-Lite slave holding the four waveform control registers (CTRL, FREQ, AMPL, PHASE)
// with independent write and read FSMs and a one-cycle per-register update strobe.
module waveform_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  waveform_axil_regs_if.slave           s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0] freq_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ampl_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0] phase_reg,
  output logic [3:0]                    reg_upd
);
  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {WIDLE, WCAPT, WRESP} wstate_e;
  typedef enum logic       {RIDLE, RDATA} rstate_e;

  wstate_e             wstate_q, wstate_d;
  rstate_e             rstate_q, rstate_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic [1:0]          widx_q, widx_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [3:0]          reg_upd_q, reg_upd_d;
  logic [DW-1:0]       regs_q [4];
  logic [DW-1:0]       regs_d [4];

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    widx_d    = widx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    reg_upd_d = '0;
    regs_d    = regs_q;
    case (wstate_q)
      WIDLE: begin
        if (s_axi.awvalid && awready_q) begin
          aw_held_d = 1'b1;
          widx_d    = s_axi.awaddr[3:2];
        end
        if (s_axi.wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.wdata;
          wstrb_d  = s_axi.wstrb;
        end
        awready_d = !aw_held_d;
        wready_d  = !w_held_d;
        // Strobe is registered on entry so it is visible exactly during WCAPT.
        if (aw_held_d && w_held_d) begin
          wstate_d          = WCAPT;
          reg_upd_d[widx_d] = 1'b1;
        end
      end
      WCAPT: begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_q[b]) regs_d[widx_q][8*b +: 8] = wdata_q[8*b +: 8];
        end
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        bvalid_d  = 1'b1;
        wstate_d  = WRESP;
      end
      WRESP: begin
        if (s_axi.bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = WIDLE;
        end
      end
      default: wstate_d = WIDLE;
    endcase
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    case (rstate_q)
      RIDLE: begin
        if (s_axi.arvalid && arready_q) begin
          rdata_d   = regs_q[s_axi.araddr[3:2]];
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          rstate_d  = RDATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      RDATA: begin
        if (s_axi.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = RIDLE;
        end
      end
      default: rstate_d = RIDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q  <= WIDLE;
      rstate_q  <= RIDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      widx_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      reg_upd_q <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      widx_q    <= widx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      reg_upd_q <= reg_upd_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_regs
    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) regs_q[gi] <= '0;
      else          regs_q[gi] <= regs_d[gi];
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;

  assign ctrl_reg  = regs_q[0];
  assign freq_reg  = regs_q[1];
  assign ampl_reg  = regs_q[2];
  assign phase_reg = regs_q[3];
  assign reg_upd   = reg_upd_q;
endmodule

// File: tb/tb_waveform_axil_regs.sv
// Self-checking bench for waveform_axil_regs: directed scenarios plus randomized
// reads/writes compared against a word-array model of the register file.
module tb_waveform_axil_regs;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ctrl_reg, freq_reg, ampl_reg, phase_reg;
  logic [3:0]  reg_upd;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model [4];
  logic [3:0]  upd_seen [$];

  always #5 clk = ~clk;

  waveform_axil_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) axi ();

  waveform_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK      (clk),
    .ARESETN   (rst_n),
    .s_axi     (axi),
    .ctrl_reg  (ctrl_reg),
    .freq_reg  (freq_reg),
    .ampl_reg  (ampl_reg),
    .phase_reg (phase_reg),
    .reg_upd   (reg_upd)
  );

  always @(negedge clk) begin
    if (rst_n && reg_upd != 4'b0) upd_seen.push_back(reg_upd);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_port(input int idx);
    case (idx)
      0:       return ctrl_reg;
      1:       return freq_reg;
      2:       return ampl_reg;
      default: return phase_reg;
    endcase
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] mask = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) mask = mask | (32'hFF << (8 * i));
    end
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Called on a falling edge; aw_dly / w_dly set when each channel's VALID rises.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_hold);
    int cyc = 0;
    int last_hs = 0;
    int wait_b;
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    int idx = int'(addr[3:2]);
    upd_seen.delete();
    axi.awaddr = addr;
    axi.awprot = 3'($urandom);
    axi.wdata  = data;
    axi.wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      if (cyc == aw_dly) axi.awvalid = 1'b1;
      if (cyc == w_dly)  axi.wvalid  = 1'b1;
      if (axi.awvalid && axi.awready) begin aw_done = 1'b1; last_hs = cyc; end
      if (axi.wvalid && axi.wready)   begin w_done  = 1'b1; last_hs = cyc; end
      @(negedge clk);
      cyc++;
      if (aw_done) axi.awvalid = 1'b0;
      if (w_done)  axi.wvalid  = 1'b0;
    end
    if (!(aw_done && w_done)) begin
      check_val("aw_w_handshake_timeout", 32'd0, 32'd1);
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      return;
    end
    wait_b = cyc - last_hs;
    while (!axi.bvalid && wait_b < 20) begin
      @(negedge clk);
      wait_b++;
    end
    check_val("bvalid_latency", 32'(wait_b), 32'd2);
    check_val("bresp", 32'(axi.bresp), 32'd0);
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      check_val("bvalid_hold", 32'(axi.bvalid), 32'd1);
      check_val("awready_blocked", 32'(axi.awready), 32'd0);
    end
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    check_val("bvalid_clear", 32'(axi.bvalid), 32'd0);
    model[idx] = strb_merge(model[idx], data, strb);
    check_val("reg_value", reg_port(idx), model[idx]);
    check_val("upd_count", 32'(upd_seen.size()), 32'd1);
    if (upd_seen.size() >= 1) check_val("upd_onehot", 32'(upd_seen[0]), 32'(1) << idx);
    $display("wr addr=0x%h data=0x%08h strb=%b aw_dly=%0d w_dly=%0d b_hold=%0d -> reg%0d=0x%08h",
             addr, data, strb, aw_dly, w_dly, b_hold, idx, model[idx]);
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_hold, output logic [31:0] data);
    int waited = 0;
    axi.araddr  = addr;
    axi.arprot  = 3'($urandom);
    axi.arvalid = 1'b1;
    data = 32'h0;
    while (!axi.arready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!axi.arready) begin
      check_val("ar_timeout", 32'd0, 32'd1);
      axi.arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    axi.arvalid = 1'b0;
    check_val("rvalid_latency", 32'(axi.rvalid), 32'd1);
    check_val("rresp", 32'(axi.rresp), 32'd0);
    data = axi.rdata;
    for (int i = 0; i < r_hold; i++) begin
      @(negedge clk);
      check_val("rvalid_hold", 32'(axi.rvalid), 32'd1);
      check_val("rdata_hold", axi.rdata, data);
      check_val("arready_blocked", 32'(axi.arready), 32'd0);
    end
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    check_val("rvalid_clear", 32'(axi.rvalid), 32'd0);
    $display("rd addr=0x%h r_hold=%0d -> data=0x%08h", addr, r_hold, data);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  a;
    rst_n = 1'b0;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) check_val("reset_reg", reg_port(i), 32'h0);
    check_val("reset_ready", 32'({axi.awready, axi.wready, axi.arready}), 32'd0);
    check_val("reset_valid", 32'({axi.bvalid, axi.rvalid}), 32'd0);
    check_val("reset_rdata", axi.rdata, 32'h0);
    check_val("reset_upd", 32'(reg_upd), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Sequential write then readback
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), 0, d);
      check_val("seq_readback", d, 32'(i + 1));
    end

    // Byte strobes
    axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'h1234_5678, 4'b0101, 0, 0, 0);
    check_val("strobe_freq", freq_reg, 32'hFF34_FF78);

    // Channel ordering: W leads AW, AW leads W, both together
    axi_write(4'h8, 32'hAAAA_0001, 4'hF, 3, 0, 0);
    axi_write(4'h8, 32'hAAAA_0002, 4'hF, 0, 3, 0);
    axi_write(4'h8, 32'hAAAA_0003, 4'hF, 0, 0, 0);
    check_val("order_ampl", ampl_reg, 32'hAAAA_0003);

    // Backpressure on B and R, plus an unaligned alias and an empty strobe
    axi_write(4'hD, 32'h5555_AAAA, 4'hF, 0, 0, 5);
    axi_read(4'hE, 5, d);
    check_val("bp_readback", d, 32'h5555_AAAA);
    axi_write(4'h1, 32'hDEAD_BEEF, 4'h0, 0, 0, 0);

    // Randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      a = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3));
      end else begin
        axi_read(a, $urandom_range(0, 3), d);
        check_val("rand_read", d, model[a[3:2]]);
      end
    end

    // Read/write collision on PHASE
    axi_write(4'hC, 32'h4, 4'hF, 0, 0, 0);
    upd_seen.delete();
    axi.awaddr = 4'hC; axi.wdata = 32'hA5; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    check_val("col_ready", 32'({axi.awready, axi.wready}), 32'd3);
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    check_val("col_upd", 32'(reg_upd), 32'h8);
    axi.araddr = 4'hC; axi.arvalid = 1'b1;
    check_val("col_arready", 32'(axi.arready), 32'd1);
    @(negedge clk);
    axi.arvalid = 1'b0;
    check_val("col_rvalid", 32'(axi.rvalid), 32'd1);
    check_val("col_old_value", axi.rdata, 32'h4);
    check_val("col_bvalid", 32'(axi.bvalid), 32'd1);
    axi.rready = 1'b1; axi.bready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0; axi.bready = 1'b0;
    model[3] = 32'hA5;
    $display("collision write PHASE=0xa5, read in capture cycle returned old value");
    axi_read(4'hC, 0, d);
    check_val("col_new_value", d, 32'hA5);

    // Asynchronous reset while both responses are pending
    axi.awaddr = 4'h0; axi.wdata = $urandom | 32'h1; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    axi.araddr = 4'h4; axi.arvalid = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("pre_reset_valids", 32'({axi.bvalid, axi.rvalid}), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_ready", 32'({axi.awready, axi.wready, axi.arready}), 32'd0);
    check_val("arst_valid", 32'({axi.bvalid, axi.rvalid}), 32'd0);
    check_val("arst_resp", 32'({axi.bresp, axi.rresp}), 32'd0);
    check_val("arst_rdata", axi.rdata, 32'h0);
    check_val("arst_upd", 32'(reg_upd), 32'd0);
    for (int i = 0; i < 4; i++) check_val("arst_reg", reg_port(i), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    upd_seen.delete();
    $display("reset asserted with BVALID and RVALID pending");
    @(negedge clk);
    axi_read(4'h0, 0, d);
    check_val("post_reset_read", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/waveform_axil_regs.md
Name: waveform_axil_regs

Overview:
AXI4-Lite slave register file forming the S00_AXI endpoint of the waveform IP; it answers the write and read bursts issued by the system master. It holds four 32-bit software-visible registers (CTRL, FREQ, AMPL, PHASE). Each register drives the waveform generator core directly, and a one-cycle update strobe fires whenever a register is written.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; the register index is addr[3:2].

Ports:
ACLK  in  1  clock; all logic is on the rising edge.
ARESETN  in  1  asynchronous active-low reset.
S_AXI_AWADDR  in  4  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  4  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response; always 2'b00.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
ctrl_reg  out  32  register 0 (offset 0x0).
freq_reg  out  32  register 1 (offset 0x4).
ampl_reg  out  32  register 2 (offset 0x8).
phase_reg  out  32  register 3 (offset 0xC).
reg_upd  out  4  one-hot, one-cycle write strobe; bit n corresponds to register n.

Behaviour:
- Reset: ARESETN low asynchronously clears the following, regardless of any in-flight transaction:
  - all READY, VALID and resp outputs;
  - S_AXI_RDATA, all four registers and reg_upd.
  - Both FSMs return to IDLE, and the master must re-issue any aborted transaction.
- Write FSM states: WIDLE, WCAPT, WRESP.
  - WIDLE: AWREADY=1 and WREADY=1. AW and W are latched independently, in either order or in the same cycle. Each ready drops for its own channel once that channel has been captured.
  - Once both AW and W are held, the FSM moves to WCAPT for one cycle.
  - WCAPT: the register at awaddr[3:2] is updated byte-wise per WSTRB, with unstrobed bytes unchanged. The matching reg_upd bit pulses in this cycle; a write with WSTRB=0 still pulses it.
  - The cycle after WCAPT, the FSM is in WRESP with BVALID=1.
  - WRESP: BVALID stays high until BREADY is sampled high, then the FSM returns to WIDLE with BVALID=0.
  - Latency: the earliest BVALID is 2 cycles after the AW/W handshake cycle.
  - Only one write is outstanding; AWREADY and WREADY stay 0 outside WIDLE.
- Read FSM states: RIDLE, RDATA.
  - RIDLE: ARREADY=1. On the ARVALID handshake, RDATA is loaded with the register at araddr[3:2] and the FSM moves to RDATA with RVALID=1 on the next cycle (1-cycle latency). ARREADY=0 while in RDATA.
  - RDATA: RDATA and RVALID are held stable until RREADY is sampled high, then the FSM returns to RIDLE.
- Read and write FSMs are fully independent.
  - A read captured in the same cycle as the WCAPT update of the same register returns the old value.
  - A read one cycle after WCAPT returns the new value.
- Address decoding:
  - addr[1:0] is ignored: unaligned addresses alias to their word.
  - The full 4-bit space decodes, so there is no SLVERR.
  - PROT is ignored.
- VALID signals never depend combinationally on READY inputs. All outputs are registered.

Test Plan:
- Sequential write/readback: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read all four -> RDATA returns 0x1..0x4, all RRESP=0, all BRESP=0, and reg_upd pulses 0001, 0010, 0100, 1000 in order.
- Byte strobes: write 0xFFFFFFFF to FREQ, then write 0x12345678 with WSTRB=4'b0101 -> freq_reg = 0xFF34FF78.
- Channel ordering: W presented 3 cycles before AW, then AW alone, then both in the same cycle -> each write lands exactly once and BVALID asserts exactly 2 cycles after the later handshake.
- Backpressure: hold BREADY=0 for 5 cycles and RREADY=0 for 5 cycles -> BVALID, RVALID and RDATA are stable throughout, and a second AW is not accepted until B completes.
- Read/write collision: write 0xA5 to PHASE (previously 0x4), with the AR for 0xC handshaken in the WCAPT cycle -> returns 0x4; the next read returns 0xA5.
- Reset mid-operation: ARESETN driven low while BVALID=1 and RVALID=1 -> all outputs go to 0 immediately, and a subsequent read of 0x0 returns 0x0.
